// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin arbiter between the CPU and a secondary (DMA)
// master for the shared 8-bit x 4K SRAM. Each granted access runs a fixed
// IDLE -> SETUP -> STROBE -> DONE sequence. Addresses in the top page are
// steered to the I/O strobe instead of the SRAM chip enable.
module ram_port_arbiter #(
   parameter int          ADDR_W  = 12,
   parameter int          DATA_W  = 8,
   parameter logic [3:0]  IO_PAGE = 4'hF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ack,
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   output logic [DATA_W-1:0] dma_rdata,
   output logic              dma_ack,
   output logic [ADDR_W-1:0] ram_a,
   output logic [DATA_W-1:0] ram_d_o,
   output logic              ram_d_oe,
   input  logic [DATA_W-1:0] ram_d_i,
   output logic              ram_ce_bar,
   output logic              ram_we_bar,
   output logic              io_sel,
   output logic              io_we,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} state_t;

   // Master ids: 0 = CPU, 1 = DMA
   localparam logic GRANT_CPU = 1'b0;
   localparam logic GRANT_DMA = 1'b1;

   state_t            state;
   state_t            state_next;
   logic              grant_q;
   logic              last_grant;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] cpu_rdata_q;
   logic [DATA_W-1:0] dma_rdata_q;
   logic              any_req;
   logic              pick_dma;
   logic              io_hit;

   assign any_req  = cpu_req | dma_req;
   // DMA wins when it is alone, or on a tie when the CPU was served last
   assign pick_dma = dma_req & (~cpu_req | (last_grant == GRANT_CPU));
   assign io_hit   = (addr_q[ADDR_W-1 -: 4] == IO_PAGE);

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: a grant always runs the full four-cycle sequence
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (any_req) state_next = SETUP;
         SETUP:   state_next = STROBE;
         STROBE:  state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Latch the winner's request at grant, capture read data, track fairness
   always_ff @(posedge clk) begin
      if (rst) begin
         grant_q     <= GRANT_CPU;
         last_grant  <= GRANT_DMA;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         cpu_rdata_q <= '0;
         dma_rdata_q <= '0;
      end else begin
         if (state == IDLE && any_req) begin
            grant_q <= pick_dma;
            we_q    <= pick_dma ? dma_we    : cpu_we;
            addr_q  <= pick_dma ? dma_addr  : cpu_addr;
            wdata_q <= pick_dma ? dma_wdata : cpu_wdata;
         end
         if (state == STROBE && !we_q) begin
            if (grant_q == GRANT_DMA) begin
               dma_rdata_q <= ram_d_i;
            end else begin
               cpu_rdata_q <= ram_d_i;
            end
         end
         if (state == DONE) begin
            last_grant <= grant_q;
         end
      end
   end

   // Pin decode purely from registered state and latched request fields
   always_comb begin
      ram_ce_bar = 1'b1;
      ram_we_bar = 1'b1;
      io_sel     = 1'b0;
      io_we      = 1'b0;
      ram_d_oe   = 1'b0;
      cpu_ack    = 1'b0;
      dma_ack    = 1'b0;
      if ((state == SETUP || state == STROBE) && we_q) begin
         ram_d_oe = 1'b1;
      end
      if (state == STROBE) begin
         if (io_hit) begin
            io_sel = 1'b1;
            io_we  = we_q;
         end else begin
            ram_ce_bar = 1'b0;
            ram_we_bar = ~we_q;
         end
      end
      if (state == DONE) begin
         cpu_ack = (grant_q == GRANT_CPU);
         dma_ack = (grant_q == GRANT_DMA);
      end
   end

   assign ram_a     = addr_q;
   assign ram_d_o   = wdata_q;
   assign cpu_rdata = cpu_rdata_q;
   assign dma_rdata = dma_rdata_q;
   assign busy      = (state != IDLE);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed test of the SRAM port arbiter. Stimulus queues
// timed pin expectations and expected acknowledges; an independent monitor
// compares them against the DUT on the falling clock edge.
module tb_ram_port_arbiter;

   localparam int SIG_CE     = 0;
   localparam int SIG_WE     = 1;
   localparam int SIG_OE     = 2;
   localparam int SIG_IOSEL  = 3;
   localparam int SIG_IOWE   = 4;
   localparam int SIG_BUSY   = 5;
   localparam int SIG_CPUACK = 6;
   localparam int SIG_DMAACK = 7;
   localparam int SIG_RAMA   = 8;
   localparam int SIG_CPURD  = 9;
   localparam int SIG_DMARD  = 10;
   localparam int SIG_MEM    = 11;

   typedef struct {
      int          cyc;
      int          sig;
      logic [11:0] addr;
      logic [11:0] exp;
      string       name;
   } chk_t;

   typedef struct {
      bit         master;
      logic [7:0] rdata;
      bit         is_read;
   } ack_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req, cpu_we, dma_req, dma_we;
   logic [11:0] cpu_addr, dma_addr, ram_a;
   logic [7:0]  cpu_wdata, dma_wdata, cpu_rdata, dma_rdata;
   logic        cpu_ack, dma_ack;
   logic [7:0]  ram_d_o, ram_d_i;
   logic        ram_d_oe, ram_ce_bar, ram_we_bar, io_sel, io_we, busy;

   logic [7:0]  mem [0:4095];
   int          cyc = 0;
   int          n_cmp = 0;
   int          n_fail = 0;
   int          chk_seen = 0;
   int          ack_head = 0;
   bit          done = 1'b0;
   logic [11:0] mon_act;
   ack_t        mon_exp;
   chk_t        chk_q[$];
   ack_t        ack_q[$];

   ram_port_arbiter dut (
      .clk        (clk),
      .rst        (rst),
      .cpu_req    (cpu_req),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_rdata  (cpu_rdata),
      .cpu_ack    (cpu_ack),
      .dma_req    (dma_req),
      .dma_we     (dma_we),
      .dma_addr   (dma_addr),
      .dma_wdata  (dma_wdata),
      .dma_rdata  (dma_rdata),
      .dma_ack    (dma_ack),
      .ram_a      (ram_a),
      .ram_d_o    (ram_d_o),
      .ram_d_oe   (ram_d_oe),
      .ram_d_i    (ram_d_i),
      .ram_ce_bar (ram_ce_bar),
      .ram_we_bar (ram_we_bar),
      .io_sel     (io_sel),
      .io_we      (io_we),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Cycle counter; cycle k spans from the k-th rising edge to the next
   always @(posedge clk) cyc <= cyc + 1;

   // SRAM model: a few known words loaded on reset, written on CE+WE low
   always @(posedge clk) begin
      if (rst) begin
         mem[12'h123] <= 8'hA5;
         mem[12'hF01] <= 8'h11;
      end else if (!ram_ce_bar && !ram_we_bar) begin
         mem[ram_a] <= ram_d_o;
      end
   end

   assign ram_d_i = (!ram_ce_bar) ? mem[ram_a] : (io_sel ? 8'h3E : 8'h00);

   function automatic logic [11:0] get_sig(input int sig, input logic [11:0] addr);
      case (sig)
         SIG_CE:     return {11'd0, ram_ce_bar};
         SIG_WE:     return {11'd0, ram_we_bar};
         SIG_OE:     return {11'd0, ram_d_oe};
         SIG_IOSEL:  return {11'd0, io_sel};
         SIG_IOWE:   return {11'd0, io_we};
         SIG_BUSY:   return {11'd0, busy};
         SIG_CPUACK: return {11'd0, cpu_ack};
         SIG_DMAACK: return {11'd0, dma_ack};
         SIG_RAMA:   return ram_a;
         SIG_CPURD:  return {4'd0, cpu_rdata};
         SIG_DMARD:  return {4'd0, dma_rdata};
         SIG_MEM:    return {4'd0, mem[addr]};
         default:    return 12'hFFF;
      endcase
   endfunction

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_at(input int c, input int sig, input logic [11:0] exp,
                            input string name, input logic [11:0] addr = 12'h000);
      chk_t e;
      e.cyc  = c;
      e.sig  = sig;
      e.addr = addr;
      e.exp  = exp;
      e.name = name;
      chk_q.push_back(e);
   endtask

   task automatic push_ack(input bit master, input logic [7:0] rdata, input bit is_read);
      ack_t a;
      a.master  = master;
      a.rdata   = rdata;
      a.is_read = is_read;
      ack_q.push_back(a);
   endtask

   task automatic apply_stimulus(input bit master, input bit we,
                                 input logic [11:0] addr, input logic [7:0] wdata);
      if (master) begin
         dma_req = 1'b1; dma_we = we; dma_addr = addr; dma_wdata = wdata;
      end else begin
         cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
      end
   endtask

   // Compare one queued expectation against the live DUT value
   task automatic check_output(input chk_t e);
      mon_act = get_sig(e.sig, e.addr);
      n_cmp++;
      chk_seen++;
      if (mon_act !== e.exp) begin
         n_fail++;
         $display("[TB] FAIL %s at cycle %0d: got %0h, want %0h", e.name, cyc, mon_act, e.exp);
      end
   endtask

   // Monitor: timed pin checks, ack scoreboard, end-of-run bookkeeping
   always @(negedge clk) begin
      foreach (chk_q[i]) begin
         if (chk_q[i].cyc == cyc) check_output(chk_q[i]);
      end
      if (cpu_ack || dma_ack) begin
         n_cmp++;
         if (cpu_ack && dma_ack) begin
            n_fail++;
            $display("[TB] FAIL both_ack at cycle %0d: got cpu=1 dma=1, want at most one", cyc);
         end
         for (int m = 0; m < 2; m++) begin
            if ((m == 0 && cpu_ack) || (m == 1 && dma_ack)) begin
               n_cmp++;
               if (ack_head >= ack_q.size()) begin
                  n_fail++;
                  $display("[TB] FAIL unexpected_ack at cycle %0d: got ack from master %0d, want none", cyc, m);
               end else begin
                  mon_exp = ack_q[ack_head];
                  ack_head++;
                  mon_act = (m == 0) ? {4'd0, cpu_rdata} : {4'd0, dma_rdata};
                  if (mon_exp.master != m[0] ||
                      (mon_exp.is_read && mon_act[7:0] !== mon_exp.rdata)) begin
                     n_fail++;
                     $display("[TB] FAIL ack_order at cycle %0d: got master=%0d rdata=%0h, want master=%0d rdata=%0h",
                              cyc, m, mon_act[7:0], mon_exp.master, mon_exp.rdata);
                  end
               end
            end
         end
      end
      if (done || cyc > 3000) begin
         if (!done) begin
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL timeout at cycle %0d: got no end of stimulus, want end", cyc);
         end
         n_cmp++;
         if (ack_head != ack_q.size()) begin
            n_fail++;
            $display("[TB] FAIL ack_pending: got %0d acks, want %0d", ack_head, ack_q.size());
         end
         n_cmp++;
         if (chk_seen != chk_q.size()) begin
            n_fail++;
            $display("[TB] FAIL chk_pending: got %0d checks, want %0d", chk_seen, chk_q.size());
         end
         $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
         $finish;
      end
   end

   // Directed stimulus sequence
   initial begin
      int n;
      int m;
      rst = 1'b1;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
      step(3);
      expect_at(cyc, SIG_BUSY,   0, "rst_busy");
      expect_at(cyc, SIG_CE,     1, "rst_ce_bar");
      expect_at(cyc, SIG_WE,     1, "rst_we_bar");
      expect_at(cyc, SIG_IOSEL,  0, "rst_io_sel");
      expect_at(cyc, SIG_IOWE,   0, "rst_io_we");
      expect_at(cyc, SIG_OE,     0, "rst_d_oe");
      expect_at(cyc, SIG_CPUACK, 0, "rst_cpu_ack");
      expect_at(cyc, SIG_DMAACK, 0, "rst_dma_ack");
      expect_at(cyc, SIG_RAMA,   0, "rst_ram_a");
      expect_at(cyc, SIG_CPURD,  0, "rst_cpu_rdata");
      expect_at(cyc, SIG_DMARD,  0, "rst_dma_rdata");
      rst = 1'b0;

      // CPU read of 0x123 (SRAM holds 0xA5)
      step(1);
      apply_stimulus(1'b0, 1'b0, 12'h123, 8'h00);
      n = cyc;
      expect_at(n+1, SIG_BUSY,   1, "rd_busy_setup");
      expect_at(n+1, SIG_RAMA,   12'h123, "rd_ram_a");
      expect_at(n+1, SIG_CE,     1, "rd_ce_setup");
      expect_at(n+2, SIG_CE,     0, "rd_ce_strobe");
      expect_at(n+3, SIG_CE,     1, "rd_ce_done");
      expect_at(n+2, SIG_WE,     1, "rd_we_strobe");
      expect_at(n+2, SIG_CPUACK, 0, "rd_ack_early");
      expect_at(n+3, SIG_CPUACK, 1, "rd_ack");
      expect_at(n+3, SIG_CPURD,  12'h0A5, "rd_rdata");
      expect_at(n+3, SIG_DMAACK, 0, "rd_dma_ack");
      expect_at(n+4, SIG_CPUACK, 0, "rd_ack_late");
      expect_at(n+4, SIG_BUSY,   0, "rd_busy_idle");
      expect_at(n+5, SIG_DMARD,  0, "rd_dma_rdata_untouched");
      push_ack(1'b0, 8'hA5, 1'b1);
      step(3);
      cpu_req = 1'b0;
      step(3);

      // DMA write 0x3C to 0x7FF
      apply_stimulus(1'b1, 1'b1, 12'h7FF, 8'h3C);
      n = cyc;
      expect_at(n+1, SIG_OE,     1, "wr_oe_setup");
      expect_at(n+2, SIG_OE,     1, "wr_oe_strobe");
      expect_at(n+3, SIG_OE,     0, "wr_oe_done");
      expect_at(n+1, SIG_WE,     1, "wr_we_setup");
      expect_at(n+2, SIG_WE,     0, "wr_we_strobe");
      expect_at(n+3, SIG_WE,     1, "wr_we_done");
      expect_at(n+3, SIG_DMAACK, 1, "wr_dma_ack");
      expect_at(n+3, SIG_CPUACK, 0, "wr_cpu_ack");
      expect_at(n+4, SIG_MEM,    12'h03C, "wr_mem", 12'h7FF);
      push_ack(1'b1, 8'h00, 1'b0);
      step(3);
      dma_req = 1'b0;
      step(3);

      // CPU write 0x55 to I/O address 0xF01
      apply_stimulus(1'b0, 1'b1, 12'hF01, 8'h55);
      n = cyc;
      expect_at(n+1, SIG_IOSEL, 0, "io_sel_setup");
      expect_at(n+2, SIG_IOSEL, 1, "io_sel_strobe");
      expect_at(n+2, SIG_IOWE,  1, "io_we_strobe");
      expect_at(n+3, SIG_IOSEL, 0, "io_sel_done");
      expect_at(n+1, SIG_CE,    1, "io_ce_setup");
      expect_at(n+2, SIG_CE,    1, "io_ce_strobe");
      expect_at(n+3, SIG_CE,    1, "io_ce_done");
      expect_at(n+4, SIG_MEM,   12'h011, "io_mem_unchanged", 12'hF01);
      push_ack(1'b0, 8'h00, 1'b0);
      step(3);
      cpu_req = 1'b0;
      step(3);

      // Continuous contention straight out of reset: CPU, DMA, CPU, DMA
      rst = 1'b1;
      apply_stimulus(1'b0, 1'b0, 12'h123, 8'h00);
      apply_stimulus(1'b1, 1'b0, 12'h7FF, 8'h00);
      step(1);
      rst = 1'b0;
      n = cyc;
      expect_at(n+3,  SIG_CPUACK, 1, "rr_cpu_ack1");
      expect_at(n+3,  SIG_DMAACK, 0, "rr_dma_idle1");
      expect_at(n+7,  SIG_DMAACK, 1, "rr_dma_ack1");
      expect_at(n+7,  SIG_CPUACK, 0, "rr_cpu_idle1");
      expect_at(n+11, SIG_CPUACK, 1, "rr_cpu_ack2");
      expect_at(n+11, SIG_DMAACK, 0, "rr_dma_idle2");
      expect_at(n+15, SIG_DMAACK, 1, "rr_dma_ack2");
      expect_at(n+15, SIG_DMARD,  12'h03C, "rr_dma_rdata");
      push_ack(1'b0, 8'hA5, 1'b1);
      push_ack(1'b1, 8'h3C, 1'b1);
      push_ack(1'b0, 8'hA5, 1'b1);
      push_ack(1'b1, 8'h3C, 1'b1);
      step(15);
      cpu_req = 1'b0;
      dma_req = 1'b0;
      step(4);

      // Reset during STROBE of a write, then re-issue
      apply_stimulus(1'b0, 1'b1, 12'h200, 8'h77);
      n = cyc;
      step(2);
      rst = 1'b1;
      cpu_req = 1'b0;
      expect_at(n+3, SIG_BUSY,   0, "abort_busy");
      expect_at(n+3, SIG_WE,     1, "abort_we_bar");
      expect_at(n+3, SIG_OE,     0, "abort_d_oe");
      expect_at(n+3, SIG_CPUACK, 0, "abort_no_ack");
      expect_at(n+4, SIG_CPUACK, 0, "abort_no_ack_late");
      step(1);
      rst = 1'b0;
      step(1);
      apply_stimulus(1'b0, 1'b1, 12'h200, 8'h78);
      m = cyc;
      expect_at(m+3, SIG_CPUACK, 1, "reissue_ack");
      expect_at(m+4, SIG_MEM,    12'h078, "reissue_mem", 12'h200);
      push_ack(1'b0, 8'h00, 1'b0);
      step(3);
      cpu_req = 1'b0;
      step(3);

      // CPU holds req after ack: back-to-back reads four cycles apart
      apply_stimulus(1'b0, 1'b0, 12'h123, 8'h00);
      n = cyc;
      expect_at(n+3, SIG_CPUACK, 1, "hold_ack1");
      expect_at(n+4, SIG_CPUACK, 0, "hold_ack1_end");
      expect_at(n+4, SIG_BUSY,   0, "hold_idle");
      expect_at(n+5, SIG_BUSY,   1, "hold_regrant");
      expect_at(n+7, SIG_CPUACK, 1, "hold_ack2");
      push_ack(1'b0, 8'hA5, 1'b1);
      push_ack(1'b0, 8'hA5, 1'b1);
      step(7);
      cpu_req = 1'b0;
      step(3);

      // CPU drops req and changes inputs right after grant; latched values win
      apply_stimulus(1'b0, 1'b1, 12'h300, 8'h9A);
      n = cyc;
      step(1);
      cpu_req   = 1'b0;
      cpu_addr  = 12'h301;
      cpu_wdata = 8'h00;
      expect_at(n+2, SIG_RAMA,   12'h300, "drop_ram_a");
      expect_at(n+3, SIG_CPUACK, 1, "drop_ack");
      expect_at(n+4, SIG_CPUACK, 0, "drop_ack_end");
      expect_at(n+4, SIG_BUSY,   0, "drop_idle");
      expect_at(n+4, SIG_MEM,    12'h09A, "drop_mem", 12'h300);
      push_ack(1'b0, 8'h00, 1'b0);
      step(6);
      done = 1'b1;
   end

endmodule
